// File: rtl/completion_tracker.sv
// Completion tracker: 2**tag_width tag table that re-orders out-of-order memory
// completions into issue order for the returner. Define CPL_TIMEOUT_EN for head-of-line timeout.
module completion_tracker #(
    parameter int unsigned data_width     = 32,
    parameter int unsigned tag_width      = 6,
    parameter int unsigned timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_is_read,
    output logic                  req_ready,
    output logic [tag_width-1:0]  req_tag,
    input  logic                  cpl_valid,
    input  logic [tag_width-1:0]  cpl_tag,
    input  logic [data_width-1:0] cpl_data,
    output logic                  ret_valid,
    output logic                  ret_is_read,
    output logic [data_width-1:0] ret_data,
    input  logic                  ret_ready,
    output logic [tag_width:0]    outstanding,
    output logic                  cpl_err
`ifdef CPL_TIMEOUT_EN
    ,
    output logic                  ret_err
`endif
);

    localparam int unsigned DEPTH = 1 << tag_width;
    localparam int unsigned CNT_W = tag_width + 1;
    localparam int unsigned TW    = tag_width;

    // The head timer is 8 bits wide, so the limit must fit in it.
    if (timeout_cycles < 1 || timeout_cycles > 255) begin : g_bad_timeout
        $error("completion_tracker: timeout_cycles must be in 1..255");
    end

    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [DEPTH-1:0]      is_read_q, is_read_d;
    logic [data_width-1:0] data_q [DEPTH];
    logic [data_width-1:0] data_d [DEPTH];
    logic [TW-1:0]         alloc_ptr_q, alloc_ptr_d;
    logic [TW-1:0]         drain_ptr_q, drain_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ret_valid_q, ret_valid_d;
    logic                  ret_is_read_q, ret_is_read_d;
    logic [data_width-1:0] ret_data_q, ret_data_d;
    logic                  cpl_err_q, cpl_err_d;
    logic                  do_alloc;
    logic                  head_ready;
    logic                  load;
    logic                  force_ret;
`ifdef CPL_TIMEOUT_EN
    logic [7:0]            timer_q, timer_d;
    logic [7:0]            timer_inc;
    logic                  ret_err_q, ret_err_d;
`endif

    assign req_ready   = (cnt_q != CNT_W'(DEPTH));
    assign req_tag     = alloc_ptr_q;
    assign outstanding = cnt_q;
    assign ret_valid   = ret_valid_q;
    assign ret_is_read = ret_is_read_q;
    assign ret_data    = ret_data_q;
    assign cpl_err     = cpl_err_q;
`ifdef CPL_TIMEOUT_EN
    assign ret_err     = ret_err_q;
    assign timer_inc   = timer_q + 8'd1;
`endif

    // Table update, completion acceptance and the output FSM.
    always_comb begin
        pending_d     = pending_q;
        done_d        = done_q;
        is_read_d     = is_read_q;
        data_d        = data_q;
        alloc_ptr_d   = alloc_ptr_q;
        drain_ptr_d   = drain_ptr_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        ret_valid_d   = ret_valid_q;
        ret_is_read_d = ret_is_read_q;
        ret_data_d    = ret_data_q;
        cpl_err_d     = 1'b0;
        load          = 1'b0;
        force_ret     = 1'b0;
        do_alloc      = req_valid && req_ready;
        head_ready    = pending_q[drain_ptr_q] && done_q[drain_ptr_q];
`ifdef CPL_TIMEOUT_EN
        timer_d       = 8'd0;
        ret_err_d     = ret_err_q;
`endif

        // Registered slot state decides legality, so a same-cycle allocation is never completable.
        if (cpl_valid) begin
            if (pending_q[cpl_tag] && !done_q[cpl_tag]) begin
                done_d[cpl_tag] = 1'b1;
                data_d[cpl_tag] = is_read_q[cpl_tag] ? cpl_data : '0;
            end else begin
                cpl_err_d = 1'b1;
            end
        end

        if (do_alloc) begin
            pending_d[alloc_ptr_q] = 1'b1;
            done_d[alloc_ptr_q]    = 1'b0;
            is_read_d[alloc_ptr_q] = req_is_read;
            alloc_ptr_d            = alloc_ptr_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                ret_valid_d = 1'b0;
                if (head_ready) begin
                    load = 1'b1;
                end
`ifdef CPL_TIMEOUT_EN
                else if (pending_q[drain_ptr_q]) begin
                    if (timer_inc == 8'(timeout_cycles)) begin
                        load      = 1'b1;
                        force_ret = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
`endif
            end
            PRESENT: begin
                if (ret_ready) begin
                    if (head_ready) begin
                        load = 1'b1;
                    end else begin
                        ret_valid_d = 1'b0;
                        state_d     = IDLE;
`ifdef CPL_TIMEOUT_EN
                        ret_err_d   = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            ret_valid_d            = 1'b1;
            ret_is_read_d          = is_read_q[drain_ptr_q];
            ret_data_d             = force_ret ? '0 : data_q[drain_ptr_q];
            pending_d[drain_ptr_q] = 1'b0;
            done_d[drain_ptr_q]    = 1'b0;
            drain_ptr_d            = drain_ptr_q + TW'(1);
            state_d                = PRESENT;
`ifdef CPL_TIMEOUT_EN
            ret_err_d              = force_ret;
`endif
        end

        unique case ({do_alloc, load})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            done_q        <= '0;
            is_read_q     <= '0;
            alloc_ptr_q   <= '0;
            drain_ptr_q   <= '0;
            cnt_q         <= '0;
            ret_valid_q   <= 1'b0;
            ret_is_read_q <= 1'b0;
            ret_data_q    <= '0;
            cpl_err_q     <= 1'b0;
`ifdef CPL_TIMEOUT_EN
            timer_q       <= 8'd0;
            ret_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            done_q        <= done_d;
            is_read_q     <= is_read_d;
            alloc_ptr_q   <= alloc_ptr_d;
            drain_ptr_q   <= drain_ptr_d;
            cnt_q         <= cnt_d;
            ret_valid_q   <= ret_valid_d;
            ret_is_read_q <= ret_is_read_d;
            ret_data_q    <= ret_data_d;
            cpl_err_q     <= cpl_err_d;
`ifdef CPL_TIMEOUT_EN
            timer_q       <= timer_d;
            ret_err_q     <= ret_err_d;
`endif
        end
    end

    // Payload storage needs no reset: it is only read once the slot's done bit is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule
